// File: rtl/spi_mgmt_regfile.sv
`default_nettype none
// spi_mgmt_regfile -- SPI opcode engine: snapshot reads of status regs, atomic control writes. Rev 1.0
module spi_mgmt_regfile #(
  parameter int         NUM_RD    = 16,
  parameter int         NUM_WR    = 4,
  parameter int         REG_BYTES = 8,
  parameter logic [7:0] ECHO_BYTE = 8'h55
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spi_rx_data_valid,
  input  logic [7:0]                      spi_rx_data,
  input  logic                            spi_cs_falling,
  output logic                            spi_tx_data_valid,
  output logic [7:0]                      spi_tx_data,
  input  logic [NUM_RD*REG_BYTES*8-1:0]   rd_regs,
  input  logic [NUM_RD*5-1:0]             rd_len,
  output logic [NUM_WR*REG_BYTES*8-1:0]   wr_regs,
  output logic [NUM_WR-1:0]               wr_strobe,
  output logic [15:0]                     bad_op_count
);

  localparam int RB8 = REG_BYTES * 8;
  localparam int KW  = $clog2(REG_BYTES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OP_HI    = 3'd1;
  localparam logic [2:0] S_DISPATCH = 3'd2;
  localparam logic [2:0] S_TX_WAIT  = 3'd3;
  localparam logic [2:0] S_WR_DATA  = 3'd4;

  localparam logic [8:0]    C_NUM_RD    = 9'(NUM_RD);
  localparam logic [8:0]    C_NUM_WR    = 9'(NUM_WR);
  localparam logic [4:0]    C_REG_BYTES = 5'(REG_BYTES);
  localparam logic [KW-1:0] C_K_LAST    = KW'(REG_BYTES - 1);
  localparam logic [KW-1:0] C_K_ONE     = KW'(1);

  logic [2:0]              state_q, state_d;
  logic [7:0]              op_lo_q, op_lo_d;
  logic [7:0]              op_hi_q, op_hi_d;
  logic [KW-1:0]           k_q, k_d;
  logic [KW-1:0]           len_q, len_d;
  logic                    pend_q, pend_d;
  logic [RB8-1:0]          snap_q, snap_d;
  logic [RB8-1:0]          shadow_q, shadow_d;
  logic [7:0]              widx_q, widx_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [NUM_WR*RB8-1:0]   wr_regs_q, wr_regs_d;
  logic [NUM_WR-1:0]       wr_strobe_q, wr_strobe_d;
  logic [15:0]             bad_op_count_q, bad_op_count_d;

  logic [RB8-1:0]          w_rd_word;
  logic [4:0]              w_len_raw;
  logic [4:0]              w_len_eff;

  assign w_rd_word = rd_regs[op_lo_q*RB8 +: RB8];
  assign w_len_raw = rd_len[op_lo_q*5 +: 5];
  assign w_len_eff = (w_len_raw > C_REG_BYTES) ? C_REG_BYTES : w_len_raw;

  always_comb begin
    state_d        = state_q;
    op_lo_d        = op_lo_q;
    op_hi_d        = op_hi_q;
    k_d            = k_q;
    len_d          = len_q;
    pend_d         = pend_q;
    snap_d         = snap_q;
    shadow_d       = shadow_q;
    widx_d         = widx_q;
    tx_valid_d     = 1'b0;
    tx_data_d      = tx_data_q;
    wr_regs_d      = wr_regs_q;
    wr_strobe_d    = '0;
    bad_op_count_d = bad_op_count_q;

    if (spi_cs_falling) begin
      state_d   = S_IDLE;
      tx_data_d = 8'h00;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spi_rx_data_valid) begin
            op_lo_d = spi_rx_data;
            state_d = S_OP_HI;
          end
        end
        S_OP_HI: begin
          if (spi_rx_data_valid) begin
            op_hi_d = spi_rx_data;
            state_d = S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          k_d    = '0;
          pend_d = 1'b0;
          if (op_hi_q == 8'h00 && op_lo_q == 8'h00) begin
            state_d   = S_IDLE;
            tx_data_d = 8'h00;
          end else if (op_hi_q == 8'h00 && op_lo_q == 8'h01) begin
            len_d      = C_K_ONE;
            tx_valid_d = 1'b1;
            tx_data_d  = ECHO_BYTE;
            state_d    = S_TX_WAIT;
          end else if (op_hi_q == 8'h01 && {1'b0, op_lo_q} < C_NUM_RD) begin
            snap_d = w_rd_word;
            len_d  = KW'(w_len_eff);
            if (w_len_eff == 5'd0) begin
              state_d   = S_IDLE;
              tx_data_d = 8'h00;
            end else begin
              tx_valid_d = 1'b1;
              tx_data_d  = w_rd_word[7:0];
              state_d    = S_TX_WAIT;
            end
          end else if (op_hi_q == 8'h02 && {1'b0, op_lo_q} < C_NUM_WR) begin
            widx_d  = op_lo_q;
            state_d = S_WR_DATA;
          end else begin
            if (bad_op_count_q != 16'hFFFF) begin
              bad_op_count_d = bad_op_count_q + 16'd1;
            end
            state_d   = S_IDLE;
            tx_data_d = 8'h00;
          end
        end
        S_TX_WAIT: begin
          // Leave one cycle after the final byte is presented so it keeps its data for the pulse.
          if (tx_valid_q && k_q == len_q - C_K_ONE) begin
            state_d   = S_IDLE;
            tx_data_d = 8'h00;
            if (spi_rx_data_valid) begin
              op_lo_d = spi_rx_data;
              state_d = S_OP_HI;
            end
          end else begin
            if (pend_q) begin
              tx_valid_d = 1'b1;
              tx_data_d  = snap_q[k_q*8 +: 8];
              pend_d     = 1'b0;
            end
            if (spi_rx_data_valid && (k_q + C_K_ONE < len_q)) begin
              k_d    = k_q + C_K_ONE;
              pend_d = 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (spi_rx_data_valid) begin
            shadow_d[k_q*8 +: 8] = spi_rx_data;
            k_d                  = k_q + C_K_ONE;
            if (k_q == C_K_LAST) begin
              wr_regs_d[widx_q*RB8 +: RB8] = shadow_d;
              wr_strobe_d[widx_q]          = 1'b1;
              state_d                      = S_IDLE;
              tx_data_d                    = 8'h00;
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          tx_data_d = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_lo_q        <= 8'h00;
      op_hi_q        <= 8'h00;
      k_q            <= '0;
      len_q          <= '0;
      pend_q         <= 1'b0;
      snap_q         <= '0;
      shadow_q       <= '0;
      widx_q         <= 8'h00;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      wr_regs_q      <= '0;
      wr_strobe_q    <= '0;
      bad_op_count_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      op_lo_q        <= op_lo_d;
      op_hi_q        <= op_hi_d;
      k_q            <= k_d;
      len_q          <= len_d;
      pend_q         <= pend_d;
      snap_q         <= snap_d;
      shadow_q       <= shadow_d;
      widx_q         <= widx_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      wr_regs_q      <= wr_regs_d;
      wr_strobe_q    <= wr_strobe_d;
      bad_op_count_q <= bad_op_count_d;
    end
  end

  assign spi_tx_data_valid = tx_valid_q;
  assign spi_tx_data       = tx_data_q;
  assign wr_regs           = wr_regs_q;
  assign wr_strobe         = wr_strobe_q;
  assign bad_op_count      = bad_op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mgmt_regfile.sv
`default_nettype none
// tb_spi_mgmt_regfile -- opcode vector table plus hand sequences, tx replies checked through a scoreboard.
module tb_spi_mgmt_regfile;
  localparam int NUM_RD    = 16;
  localparam int NUM_WR    = 4;
  localparam int REG_BYTES = 8;
  localparam int RB8       = REG_BYTES * 8;
  localparam int GAP       = 3;
  localparam int NVEC      = 11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   rx_v = 1'b0;
  logic [7:0]             rx_d = 8'h00;
  logic                   cs = 1'b0;
  logic                   tx_v;
  logic [7:0]             tx_d;
  logic [NUM_RD*RB8-1:0]  rd_regs;
  logic [NUM_RD*5-1:0]    rd_len;
  logic [NUM_WR*RB8-1:0]  wr_regs;
  logic [NUM_WR-1:0]      wr_strobe;
  logic [15:0]            bad;

  spi_mgmt_regfile #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .REG_BYTES(REG_BYTES), .ECHO_BYTE(8'h55)
  ) dut (
    .clk(clk), .rst(rst),
    .spi_rx_data_valid(rx_v), .spi_rx_data(rx_d), .spi_cs_falling(cs),
    .spi_tx_data_valid(tx_v), .spi_tx_data(tx_d),
    .rd_regs(rd_regs), .rd_len(rd_len),
    .wr_regs(wr_regs), .wr_strobe(wr_strobe), .bad_op_count(bad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t sb[$];

  typedef struct { logic [7:0] lo; logic [7:0] hi; int n_bytes; int bad_inc; } vec_t;
  vec_t vecs[NVEC];

  int          strobe_cnt [NUM_WR] = '{default: 0};
  int          strobe_cyc = -1;
  int          last_cyc   = 0;
  int          exp_bad    = 0;
  logic [63:0] mdl_reg [NUM_RD];
  logic [4:0]  mdl_len [NUM_RD];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply_regs();
    for (int i = 0; i < NUM_RD; i++) begin
      rd_regs[i*RB8 +: RB8] = mdl_reg[i];
      rd_len[i*5 +: 5]      = mdl_len[i];
    end
  endtask

  task automatic send(input logic [7:0] b, input bit has_exp, input logic [7:0] eb);
    exp_t e;
    @(negedge clk);
    rx_v = 1'b1;
    rx_d = b;
    last_cyc = cyc;
    if (has_exp) begin
      e.data = eb;
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    rx_v = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  // Scoreboard consumer and strobe tally.
  always @(negedge clk) begin
    if (tx_v) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %02h, required no reply", tx_d);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_data", 64'(tx_d), 64'(e.data));
        chk("tx_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_strobe[j]) begin
        strobe_cnt[j]++;
        strobe_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap;
    logic [7:0]  first;
    int          n;

    for (int i = 0; i < NUM_RD; i++) begin
      for (int k = 0; k < REG_BYTES; k++) mdl_reg[i][k*8 +: 8] = {4'(i), 4'(k)};
      mdl_len[i] = 5'd2;
    end
    mdl_len[0] = 5'd4; mdl_len[3] = 5'd3; mdl_len[5] = 5'd0; mdl_len[7] = 5'd20; mdl_len[15] = 5'd1;
    apply_regs();

    vecs[0]  = '{8'h00, 8'h00, 0, 0};
    vecs[1]  = '{8'h01, 8'h00, 1, 0};
    vecs[2]  = '{8'h03, 8'h01, 3, 0};
    vecs[3]  = '{8'h05, 8'h01, 0, 0};
    vecs[4]  = '{8'h07, 8'h01, 8, 0};
    vecs[5]  = '{8'h0F, 8'h01, 1, 0};
    vecs[6]  = '{8'hFF, 8'h00, 0, 1};
    vecs[7]  = '{8'h10, 8'h01, 0, 1};
    vecs[8]  = '{8'h04, 8'h02, 0, 1};
    vecs[9]  = '{8'h00, 8'h03, 0, 1};
    vecs[10] = '{8'h02, 8'h00, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 64'(tx_v), 64'd0);
    chk("rst_tx_data", 64'(tx_d), 64'd0);
    chk("rst_wr_regs", 64'(|wr_regs), 64'd0);
    chk("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    chk("rst_bad_count", 64'(bad), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Opcode table
    for (int v = 0; v < NVEC; v++) begin
      n    = vecs[v].n_bytes;
      snap = 64'h0;
      if (vecs[v].hi == 8'h00) snap = 64'h55;
      else if (vecs[v].hi == 8'h01 && n > 0) snap = mdl_reg[vecs[v].lo[3:0]];
      first = snap[7:0];
      send(vecs[v].lo, 1'b0, 8'h00);
      send(vecs[v].hi, n > 0, first);
      for (int k = 1; k < n; k++) send(8'hA5, 1'b1, snap[k*8 +: 8]);
      repeat (4) @(negedge clk);
      exp_bad += vecs[v].bad_inc;
      chk("vec_bad_count", 64'(bad), 64'(exp_bad));
      chk("vec_sb_drained", 64'(sb.size()), 64'd0);
    end

    // READ reg0 len 4, then a fourth dummy becomes the next opcode low byte (ECHO)
    mdl_reg[0] = 64'h11223344_DDCCBBAA;
    apply_regs();
    send(8'h00, 1'b0, 8'h00);
    send(8'h01, 1'b1, 8'hAA);
    send(8'h00, 1'b1, 8'hBB);
    send(8'h00, 1'b1, 8'hCC);
    send(8'h00, 1'b1, 8'hDD);
    repeat (3) @(negedge clk);
    chk("read4_idle_tx_data", 64'(tx_d), 64'd0);
    send(8'h01, 1'b0, 8'h00);
    send(8'h00, 1'b1, 8'h55);
    repeat (4) @(negedge clk);
    chk("read4_sb_drained", 64'(sb.size()), 64'd0);

    // Snapshot isolation
    mdl_len[0] = 5'd8;
    mdl_reg[0] = 64'h08070605_04030201;
    apply_regs();
    snap = mdl_reg[0];
    send(8'h00, 1'b0, 8'h00);
    send(8'h01, 1'b1, snap[7:0]);
    mdl_reg[0] = 64'hFFEEDDCC_BBAA9988;
    apply_regs();
    for (int k = 1; k < 8; k++) begin
      send(8'h00, 1'b1, snap[k*8 +: 8]);
      mdl_reg[0] = mdl_reg[0] ^ 64'h0F0F0F0F_0F0F0F0F;
      apply_regs();
    end
    repeat (4) @(negedge clk);
    chk("snap_sb_drained", 64'(sb.size()), 64'd0);

    // WRITE reg1
    send(8'h01, 1'b0, 8'h00);
    send(8'h02, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) send(8'(8'h11 * (k + 1)), 1'b0, 8'h00);
    chk("wr1_value", wr_regs[1*RB8 +: RB8], 64'h88776655_44332211);
    chk("wr1_strobe_cnt", 64'(strobe_cnt[1]), 64'd1);
    chk("wr1_strobe_cycle", 64'(strobe_cyc), 64'(last_cyc + 1));
    chk("wr0_strobe_cnt", 64'(strobe_cnt[0]), 64'd0);

    // Partial WRITE reg0 aborted by CS#, with a same-cycle rx byte that must be dropped
    send(8'h00, 1'b0, 8'h00);
    send(8'h02, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) send(8'hC0 + 8'(k), 1'b0, 8'h00);
    @(negedge clk);
    cs = 1'b1; rx_v = 1'b1; rx_d = 8'h01;
    @(negedge clk);
    cs = 1'b0; rx_v = 1'b0;
    send(8'h00, 1'b0, 8'h00);
    send(8'h00, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("abort_wr0_value", wr_regs[0 +: RB8], 64'h0);
    chk("abort_wr0_strobe", 64'(strobe_cnt[0]), 64'd0);
    chk("abort_sb_drained", 64'(sb.size()), 64'd0);
    send(8'h00, 1'b0, 8'h00);
    send(8'h02, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) send(8'hA0 + 8'(k), 1'b0, 8'h00);
    chk("rewr0_value", wr_regs[0 +: RB8], 64'hA7A6A5A4_A3A2A1A0);
    chk("rewr0_strobe", 64'(strobe_cnt[0]), 64'd1);

    // Reset in the middle of a WRITE
    send(8'h02, 1'b0, 8'h00);
    send(8'h02, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) send(8'h70 + 8'(k), 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_tx_valid", 64'(tx_v), 64'd0);
    chk("mrst_tx_data", 64'(tx_d), 64'd0);
    chk("mrst_wr_regs", 64'(|wr_regs), 64'd0);
    chk("mrst_wr_strobe", 64'(wr_strobe), 64'd0);
    chk("mrst_bad_count", 64'(bad), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    send(8'h01, 1'b0, 8'h00);
    send(8'h00, 1'b1, 8'h55);
    repeat (4) @(negedge clk);
    chk("mrst_wr2_strobe", 64'(strobe_cnt[2]), 64'd0);
    chk("mrst_sb_drained", 64'(sb.size()), 64'd0);

    // Bad opcode counting and saturation
    send(8'hFF, 1'b0, 8'h00);
    send(8'h00, 1'b0, 8'h00);
    send(8'h10, 1'b0, 8'h00);
    send(8'h01, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("bad_count_two", 64'(bad), 64'd2);
    force dut.bad_op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.bad_op_count_q;
    @(negedge clk);
    send(8'h00, 1'b0, 8'h00);
    send(8'h03, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("bad_count_sat1", 64'(bad), 64'hFFFF);
    send(8'h00, 1'b0, 8'h00);
    send(8'h03, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("bad_count_sat2", 64'(bad), 64'hFFFF);

    repeat (4) @(negedge clk);
    chk("final_sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
